// File: rtl/uart_echo_host_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_echo_host_if
//  Brief    : Register-bus bundle between the echo host (initiator) and the
//             UART register block (target).
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_echo_host_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output cs,
        output read,
        output write,
        output addr,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  cs,
        input  read,
        input  write,
        input  addr,
        input  wr_data,
        output rd_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_echo_host.sv
`default_nettype none
// ============================================================================
//  Module   : uart_echo_host
//  Brief    : Programs the UART baud divisor once after reset, then loops:
//             poll status, pop one RX byte, wait for TX room, write the byte
//             back out. Tracks the number of echoed bytes and the last byte.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_echo_host #(
    parameter int SYS_CLK_FREQ = 50000000,
    parameter int BAUD_RATE    = 19200
) (
    input  wire                clk,
    input  wire                reset,       // asynchronous, active-low
    input  wire                enable,
    uart_echo_host_if.master   bus,
    output logic [15:0]        echo_count,
    output logic [7:0]         last_byte,
    output logic               busy
);

    localparam int          DVSR_INT = SYS_CLK_FREQ / BAUD_RATE / 16;
    localparam logic [31:0] DVSR     = 32'(DVSR_INT);

    localparam logic [4:0]  c_ADDR_STATUS = 5'b00000;
    localparam logic [4:0]  c_ADDR_DVSR   = 5'b00001;
    localparam logic [4:0]  c_ADDR_TX     = 5'b00010;
    localparam logic [4:0]  c_ADDR_POP    = 5'b00011;

    typedef enum logic [2:0] {
        S_CFG    = 3'd0,
        S_POLL   = 3'd1,
        S_POP    = 3'd2,
        S_TXWAIT = 3'd3,
        S_TXWR   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_byte;
    logic [15:0] r_echo_count;
    logic [7:0]  r_last_byte;

    logic        w_cs;
    logic        w_read;
    logic        w_write;
    logic [4:0]  w_addr;
    logic [31:0] w_wr_data;

    logic        w_rx_empty;
    logic        w_tx_full;
    logic        w_capture;
    logic        w_unused_rd;

    assign w_rx_empty  = bus.rd_data[8];
    assign w_tx_full   = bus.rd_data[9];
    assign w_unused_rd = ^bus.rd_data[31:10];

    // A byte is taken only from POLL, and only while enabled with data present.
    assign w_capture = (r_state == S_POLL) && enable && !w_rx_empty;

    // State register; reset parks the machine in CFG so the divisor is rewritten.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_CFG;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state from status bits; bus outputs from state and captured byte only.
    always_comb begin
        w_next    = r_state;
        w_cs      = 1'b0;
        w_read    = 1'b0;
        w_write   = 1'b0;
        w_addr    = c_ADDR_STATUS;
        w_wr_data = 32'd0;
        case (r_state)
            S_CFG: begin
                w_cs      = 1'b1;
                w_write   = 1'b1;
                w_addr    = c_ADDR_DVSR;
                w_wr_data = DVSR;
                w_next    = S_POLL;
            end
            S_POLL: begin
                w_cs   = 1'b1;
                w_read = 1'b1;
                if (enable && !w_rx_empty) begin
                    w_next = S_POP;
                end
            end
            S_POP: begin
                w_cs    = 1'b1;
                w_write = 1'b1;
                w_addr  = c_ADDR_POP;
                w_next  = S_TXWAIT;
            end
            S_TXWAIT: begin
                w_cs   = 1'b1;
                w_read = 1'b1;
                if (!w_tx_full) begin
                    w_next = S_TXWR;
                end
            end
            S_TXWR: begin
                w_cs      = 1'b1;
                w_write   = 1'b1;
                w_addr    = c_ADDR_TX;
                w_wr_data = {24'd0, r_byte};
                w_next    = S_POLL;
            end
            default: begin
                w_next = S_CFG;
            end
        endcase
    end

    // Byte capture register, loaded from the RX FIFO head when leaving POLL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte <= 8'd0;
        end else if (w_capture) begin
            r_byte <= bus.rd_data[7:0];
        end
    end

    // Echo statistics update on the TX write cycle; counter wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_echo_count <= 16'd0;
            r_last_byte  <= 8'd0;
        end else if (r_state == S_TXWR) begin
            r_echo_count <= r_echo_count + 16'd1;
            r_last_byte  <= r_byte;
        end
    end

    // Bus outputs are forced low the instant reset asserts, even though the
    // state register sits in CFG during reset.
    assign bus.cs      = reset & w_cs;
    assign bus.read    = reset & w_read;
    assign bus.write   = reset & w_write;
    assign bus.addr    = reset ? w_addr : 5'd0;
    assign bus.wr_data = reset ? w_wr_data : 32'd0;

    assign echo_count = r_echo_count;
    assign last_byte  = r_last_byte;
    assign busy       = (r_state != S_POLL);

endmodule
`default_nettype wire
